// File: rtl/tdm_demux4.sv
// Receive side of a 4:1 TDM link: aligns to the slot-0 frame marker and
// recovers four channels into registered parallel outputs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | not aligned; waiting for a marker sample to start a frame
// LOCKED | aligned; slot counter tracks the incoming frame position
module tdm_demux4 #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             fsync_i,
  output logic [WIDTH-1:0] out_a_o,
  output logic [WIDTH-1:0] out_b_o,
  output logic [WIDTH-1:0] out_c_o,
  output logic [WIDTH-1:0] out_d_o,
  output logic             sel0_o,
  output logic             sel1_o,
  output logic             locked_o,
  output logic             frame_valid_o,
  output logic             sync_err_o
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [2:0]       miss_q, miss_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d;
  logic [WIDTH-1:0] shadow1_q, shadow1_d;
  logic [WIDTH-1:0] shadow2_q, shadow2_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;
  logic             fv_q, fv_d;
  logic             se_q, se_d;

  logic [3:0]       miss_inc;
  logic             miss_exhausted;

  assign miss_inc       = {1'b0, miss_q} + 4'd1;
  assign miss_exhausted = (miss_inc >= 4'(MISS_LIMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HUNT;
      slot_q    <= 2'd0;
      miss_q    <= 3'd0;
      shadow0_q <= '0;
      shadow1_q <= '0;
      shadow2_q <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_c_q   <= '0;
      out_d_q   <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      miss_q    <= miss_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      shadow2_q <= shadow2_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_c_q   <= out_c_d;
      out_d_q   <= out_d_d;
      fv_q      <= fv_d;
      se_q      <= se_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    miss_d    = miss_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_c_d   = out_c_q;
    out_d_d   = out_d_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;

    if (en_i) begin
      unique case (state_q)
        HUNT: begin
          if (fsync_i) begin
            shadow0_d = din_i;
            slot_d    = 2'd1;
            miss_d    = 3'd0;
            state_d   = LOCKED;
          end
        end

        LOCKED: begin
          if (fsync_i && (slot_q != 2'd0)) begin
            // Marker in the wrong slot: drop the partial frame, realign here.
            se_d      = 1'b1;
            shadow0_d = din_i;
            slot_d    = 2'd1;
            miss_d    = 3'd0;
          end else begin
            unique case (slot_q)
              2'd0: begin
                if (fsync_i) begin
                  shadow0_d = din_i;
                  slot_d    = 2'd1;
                  miss_d    = 3'd0;
                end else if (miss_exhausted) begin
                  state_d = HUNT;
                  slot_d  = 2'd0;
                  miss_d  = 3'd0;
                end else begin
                  miss_d    = miss_inc[2:0];
                  shadow0_d = din_i;
                  slot_d    = 2'd1;
                end
              end
              2'd1: begin
                shadow1_d = din_i;
                slot_d    = 2'd2;
              end
              2'd2: begin
                shadow2_d = din_i;
                slot_d    = 2'd3;
              end
              default: begin
                out_a_d = shadow0_q;
                out_b_d = shadow1_q;
                out_c_d = shadow2_q;
                out_d_d = din_i;
                fv_d    = 1'b1;
                slot_d  = 2'd0;
              end
            endcase
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  assign out_a_o       = out_a_q;
  assign out_b_o       = out_b_q;
  assign out_c_o       = out_c_q;
  assign out_d_o       = out_d_q;
  assign sel0_o        = slot_q[0];
  assign sel1_o        = slot_q[1];
  assign locked_o      = (state_q == LOCKED);
  assign frame_valid_o = fv_q;
  assign sync_err_o    = se_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: scenario tasks compared against a frame-level
// reference model of the link receiver.
module tb_tdm_demux4;
  localparam int W  = 1;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en_i = 1'b0;
  logic         fsync_i = 1'b0;
  logic [W-1:0] din_i = '0;
  logic [W-1:0] out_a_o, out_b_o, out_c_o, out_d_o;
  logic         sel0_o, sel1_o, locked_o, frame_valid_o, sync_err_o;

  tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(ML)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .din_i(din_i), .fsync_i(fsync_i),
    .out_a_o(out_a_o), .out_b_o(out_b_o), .out_c_o(out_c_o), .out_d_o(out_d_o),
    .sel0_o(sel0_o), .sel1_o(sel1_o), .locked_o(locked_o),
    .frame_valid_o(frame_valid_o), .sync_err_o(sync_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [4*W+4:0] obs;
  assign obs = {out_a_o, out_b_o, out_c_o, out_d_o, sel1_o, sel0_o,
                locked_o, frame_valid_o, sync_err_o};

  // Reference model: frame position, miss count, captured samples, last frame.
  bit           m_locked;
  int           m_slot;
  int           m_miss;
  logic [W-1:0] m_sh  [3];
  logic [W-1:0] m_out [4];
  bit           m_fv, m_se;

  function automatic void model_reset();
    m_locked = 0; m_slot = 0; m_miss = 0; m_fv = 0; m_se = 0;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;
  endfunction

  function automatic logic [4*W+4:0] exp_vec();
    logic [1:0] s;
    s = 2'(m_slot);
    return {m_out[0], m_out[1], m_out[2], m_out[3], s[1], s[0],
            1'(m_locked), 1'(m_fv), 1'(m_se)};
  endfunction

  function automatic void model_sample(input bit fs, input logic [W-1:0] d);
    if (!m_locked) begin
      if (fs) begin m_sh[0] = d; m_slot = 1; m_miss = 0; m_locked = 1; end
    end else if (fs) begin
      m_se   = (m_slot != 0);
      m_sh[0] = d; m_slot = 1; m_miss = 0;
    end else if (m_slot == 0) begin
      m_miss = m_miss + 1;
      if (m_miss >= ML) begin m_locked = 0; m_slot = 0; m_miss = 0; end
      else begin m_sh[0] = d; m_slot = 1; end
    end else if (m_slot == 3) begin
      m_out[0] = m_sh[0]; m_out[1] = m_sh[1]; m_out[2] = m_sh[2]; m_out[3] = d;
      m_fv = 1; m_slot = 0;
    end else begin
      m_sh[m_slot] = d; m_slot = m_slot + 1;
    end
  endfunction

  // Drive one cycle and advance the model; leaves time at posedge+1.
  task automatic step(input bit en, input bit fs, input logic [W-1:0] d);
    en_i = en; fsync_i = fs; din_i = d;
    @(posedge clk);
    m_fv = 0; m_se = 0;
    if (en) model_sample(fs, d);
    #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    en_i = 1'b0; fsync_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      en_i = 1'b1; fsync_i = k[0]; din_i = W'(k % 2);
      @(posedge clk); #1;
      total++;
      if (obs !== '0) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%b want=0", k, obs);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, W'($urandom));
      total++;
      if (obs !== exp_vec() || locked_o !== 1'b0 || frame_valid_o !== 1'b0) begin
        bad++; $display("FAIL reset_nofsync cyc=%0d got=%b want=%b", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] d;
    d = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, W'(d[3-i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL basic cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    total++;
    if ({out_a_o, out_b_o, out_c_o, out_d_o, frame_valid_o} !== 5'b1011_1) begin
      bad++; $display("FAIL basic_outs got=%b%b%b%b fv=%b want=1011 fv=1",
                      out_a_o, out_b_o, out_c_o, out_d_o, frame_valid_o);
    end
    step(1'b0, 1'b0, '0);
    total++;
    if (frame_valid_o !== 1'b0 || obs !== exp_vec()) begin
      bad++; $display("FAIL basic_fv_drop got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_en_gaps();
    logic [3:0] d;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, '0);
    d = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, W'(d[3-i]));
      pulses += int'(frame_valid_o);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL gaps_en cyc=%0d got=%b want=%b", i, obs, exp_vec());
      end
      repeat (1 + $urandom_range(0, 2)) begin
        step(1'b0, 1'($urandom), W'($urandom));
        pulses += int'(frame_valid_o);
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL gaps_idle cyc=%0d got=%b want=%b", i, obs, exp_vec());
        end
      end
    end
    total++;
    if (pulses != 1 || {out_a_o, out_b_o, out_c_o, out_d_o} !== 4'b1011) begin
      bad++; $display("FAIL gaps_result pulses=%0d outs=%b%b%b%b want 1 and 1011",
                      pulses, out_a_o, out_b_o, out_c_o, out_d_o);
    end
  endtask

  task automatic test_exhaustive();
    int pulses;
    logic [3:0] v;
    pulses = 0;
    for (int f = 0; f < 16; f++) begin
      v = 4'(f);
      for (int i = 0; i < 4; i++) begin
        step(1'b1, i == 0, W'(v[3-i]));
        pulses += int'(frame_valid_o);
        total++;
        if (obs !== exp_vec()) begin
          bad++; $display("FAIL exh f=%0d s=%0d got=%b want=%b", f, i, obs, exp_vec());
        end
      end
      total++;
      if ({out_a_o, out_b_o, out_c_o, out_d_o} !== v) begin
        bad++; $display("FAIL exh_outs f=%0d got=%b%b%b%b want=%b",
                        f, out_a_o, out_b_o, out_c_o, out_d_o, v);
      end
    end
    total++;
    if (pulses != 16) begin
      bad++; $display("FAIL exh_pulses got=%0d want=16", pulses);
    end
  endtask

  task automatic test_misalign();
    logic [3:0] nf;
    int pulses;
    pulses = 0;
    step(1'b1, 1'b1, '1);
    step(1'b1, 1'b0, '0);
    nf = 4'($urandom);
    step(1'b1, 1'b1, W'(nf[3]));
    total++;
    if (sync_err_o !== 1'b1 || locked_o !== 1'b1 || obs !== exp_vec()) begin
      bad++; $display("FAIL misalign_s2 got=%b want=%b", obs, exp_vec());
    end
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, W'(nf[3-i]));
      pulses += int'(frame_valid_o);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL misalign_refr s=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    total++;
    if (pulses != 1 || {out_a_o, out_b_o, out_c_o, out_d_o} !== nf) begin
      bad++; $display("FAIL misalign_newframe pulses=%0d got=%b%b%b%b want=%b",
                      pulses, out_a_o, out_b_o, out_c_o, out_d_o, nf);
    end
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, W'($urandom));
    step(1'b1, 1'b1, W'($urandom));
    total++;
    if (sync_err_o !== 1'b1 || frame_valid_o !== 1'b0 || obs !== exp_vec()) begin
      bad++; $display("FAIL misalign_s3 got=%b want=%b", obs, exp_vec());
    end
  endtask

  task automatic test_loss_lock();
    logic [3:0] held;
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, W'($urandom));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      total++;
      if (obs !== exp_vec() || locked_o !== 1'b1) begin
        bad++; $display("FAIL loss_first s=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    held = {out_a_o, out_b_o, out_c_o, out_d_o};
    step(1'b1, 1'b0, W'($urandom));
    total++;
    if (locked_o !== 1'b0 || {out_a_o, out_b_o, out_c_o, out_d_o} !== held ||
        obs !== exp_vec()) begin
      bad++; $display("FAIL loss_drop got=%b want=%b", obs, exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i == 0, W'($urandom));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL loss_relock s=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
    step(1'b1, 1'b1, '1);
    step(1'b1, 1'b0, '1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL loss_midreset got=%b want=0", obs);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '1);
      total++;
      if (obs !== exp_vec() || locked_o !== 1'b0) begin
        bad++; $display("FAIL loss_postreset s=%0d got=%b want=%b", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit en, fs;
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      fs = (m_slot == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      step(en, fs, W'($urandom));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_gaps();
    test_exhaustive();
    test_misalign();
    test_loss_lock();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive side of the 4:1 TDM link. Takes the serial stream produced by a 4:1 mux whose select lines step through slots 0..3, and recovers the four channels into registered parallel outputs.
- Aligns to a frame-sync marker on slot 0. Flags misalignment and drops lock after repeated missing markers.
- Sits between the link input and the per-channel consumers.

Parameters:
- WIDTH, 1, bit width of each channel sample and of DIN.
- MISS_LIMIT, 2, consecutive slot-0 boundaries without FSYNC tolerated before lock is dropped (legal range 1..7).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  sample strobe; DIN/FSYNC are sampled only on cycles where EN=1.
- DIN  input  WIDTH  TDM data for the current slot.
- FSYNC  input  1  high with EN on the slot-0 sample of a frame.
- OUT_A  output  WIDTH  channel 0 (slot 0) from the last complete frame.
- OUT_B  output  WIDTH  channel 1 (slot 1).
- OUT_C  output  WIDTH  channel 2 (slot 2).
- OUT_D  output  WIDTH  channel 3 (slot 3).
- SEL0  output  1  expected slot for the next EN sample, bit 0.
- SEL1  output  1  expected slot for the next EN sample, bit 1.
- LOCKED  output  1  high while aligned.
- FRAME_VALID  output  1  one-cycle pulse when OUT_A..OUT_D have just been updated.
- SYNC_ERR  output  1  one-cycle pulse when FSYNC arrives at a non-zero slot.

Behaviour:
- Reset (RST_N=0, async): OUT_A..OUT_D=0, SEL1:SEL0=00, LOCKED=0, FRAME_VALID=0, SYNC_ERR=0, shadow regs=0, miss counter=0, state=HUNT.
- Slot number is {SEL1,SEL0}.
- No state changes on EN=0 cycles. FRAME_VALID and SYNC_ERR still return to 0 after a pulse.
- HUNT:
  - EN=1, FSYNC=0: ignored.
  - EN=1, FSYNC=1: shadow0<=DIN, slot<=1, miss<=0, state<=LOCKED.
- LOCKED, on each EN=1:
  - slot 1 or 2: shadow[slot]<=DIN, slot<=slot+1.
  - slot 3: OUT_A<=shadow0, OUT_B<=shadow1, OUT_C<=shadow2, OUT_D<=DIN in the same edge. FRAME_VALID=1 for the following cycle. slot<=0 (wrap).
  - slot 0 with FSYNC=1: shadow0<=DIN, slot<=1, miss<=0.
  - slot 0 with FSYNC=0 (missed marker): miss<=miss+1. If miss+1 reaches MISS_LIMIT, go to HUNT and set slot<=0. Otherwise treat the sample as slot 0 (shadow0<=DIN, slot<=1).
  - FSYNC=1 at slot 1/2/3 (misalignment):
    - SYNC_ERR=1 next cycle.
    - Partial frame discarded: outputs not updated and FRAME_VALID not pulsed, even at slot 3.
    - Sample taken as slot 0: shadow0<=DIN, slot<=1, miss<=0. Stays LOCKED.
- Latency: OUT_* and FRAME_VALID are valid one CLK after the EN edge that samples slot 3.
- OUT_* hold their value between frames and when dropping to HUNT.
- LOCKED output equals state==LOCKED and is registered.
- Reset asserted mid-frame clears everything immediately. The first frame after release requires FSYNC.

Test Plan:
- Reset: RST_N=0 with DIN=1 toggling -> all outputs 0, LOCKED=0. Release and hold FSYNC=0 for 8 EN cycles -> LOCKED stays 0, FRAME_VALID never pulses.
- Basic frame (WIDTH=1): EN=1 each cycle, FSYNC on first sample, DIN sequence 1,0,1,1 -> after 4th edge OUT_A..D=1,0,1,1 and FRAME_VALID pulses for exactly 1 cycle.
- EN gaps: same frame with EN=0 inserted between every sample -> identical OUT values, slot holds during gaps, FRAME_VALID pulses once.
- Exhaustive: 16 frames carrying {A,B,C,D}=i for i=0..15, FSYNC each frame -> after frame i, OUT_A..D equal bits 3..0 of i, and 16 FRAME_VALID pulses.
- Misalignment: FSYNC asserted at slot 2 -> SYNC_ERR pulse, no FRAME_VALID for the broken frame, next frame decoded correctly from the new alignment.
- Loss of lock: MISS_LIMIT=2, two consecutive frames without FSYNC -> first miss stays LOCKED and decodes, second miss drops LOCKED=0 with OUT_* held. A new FSYNC relocks. Then assert RST_N=0 at slot 2 -> immediate clear.
